// File: rtl/aes_mch_pkg.sv
// Shared definitions for the multi-channel AES request/reseed controller.
// FSM state encoding, tag FIFO depth and the channel-id width helper.
package aes_mch_pkg;

    localparam int TAG_DEPTH = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAITB = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aes_enc_mch_reseed_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; purely combinational.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end

endmodule

// File: rtl/aes_enc_mch_reseed_ctrl.sv
// Merges NCH request streams into a masked AES core, tags results by channel and schedules PRNG reseeds.
// Request path is combinational; requests stall while a reseed is pending/running or the tag FIFO is full.
module aes_enc_mch_reseed_ctrl
    import aes_mch_pkg::*;
#(
    parameter int d             = 2,
    parameter int NCH           = 4,
    parameter int SEED_W        = 80,
    parameter int RESEED_PERIOD = 0,
    parameter int CNT_W         = 16,
    localparam int CH_W         = ch_w(NCH),
    localparam int SW           = 128 * d
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      ch_valid,
    output logic [NCH-1:0]      ch_ready,
    input  logic [NCH*SW-1:0]   ch_shares_pt,
    input  logic [NCH*SW-1:0]   ch_shares_key,
    output logic                core_valid_in,
    input  logic                core_in_ready,
    input  logic                core_busy,
    output logic [SW-1:0]       core_shares_pt,
    output logic [SW-1:0]       core_shares_key,
    input  logic                core_cipher_valid,
    output logic                core_out_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    input  logic                in_seed_valid,
    output logic                in_seed_ready,
    input  logic [SEED_W-1:0]   in_seed,
    output logic [SEED_W-1:0]   prng_seed,
    output logic                prng_start_reseed,
    input  logic                prng_busy,
    input  logic                prng_out_valid,
    output logic                reseed_due
);

    localparam int TP_W = $clog2(TAG_DEPTH);
    localparam int TC_W = $clog2(TAG_DEPTH + 1);

    logic [2:0]        state_q, state_d;
    logic              seed_full_q, seed_full_d;
    logic [SEED_W-1:0] prng_seed_q, prng_seed_d;
    logic              reseed_due_q, reseed_due_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              hold_q, hold_d;
    logic [CH_W-1:0]   hold_idx_q, hold_idx_d;
    logic [CH_W-1:0]   tag_mem_q [TAG_DEPTH];
    logic [CH_W-1:0]   tag_mem_d [TAG_DEPTH];
    logic [TP_W-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [TC_W-1:0]   tag_cnt_q, tag_cnt_d;

    logic [NCH-1:0]    arb_gnt, g_oh;
    logic [CH_W-1:0]   arb_idx, g_idx;
    logic              arb_any, fifo_full, fifo_empty, idle_ok, accept, pop;

    rr_arbiter #(.N(NCH), .W(CH_W)) u_arb (
        .req (ch_valid),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // A request offered but not yet taken keeps its grant, even if a seed lands meanwhile.
    always_comb begin
        fifo_full  = (tag_cnt_q == TC_W'(TAG_DEPTH));
        fifo_empty = (tag_cnt_q == '0);
        idle_ok    = (state_q == ST_IDLE) & ~seed_full_q & ~reseed_due_q;
        g_idx      = hold_q ? hold_idx_q : arb_idx;
        for (int i = 0; i < NCH; i++) begin
            g_oh[i] = hold_q ? (hold_idx_q == CH_W'(i)) : arb_gnt[i];
        end
        core_valid_in = prng_out_valid & ~fifo_full &
                        (hold_q ? ch_valid[hold_idx_q] : (idle_ok & arb_any));
        accept   = core_valid_in & core_in_ready;
        pop      = core_cipher_valid & out_ready & ~fifo_empty;
        ch_ready = accept ? g_oh : '0;
        core_shares_pt  = ch_shares_pt[g_idx*SW +: SW];
        core_shares_key = ch_shares_key[g_idx*SW +: SW];
    end

    always_comb begin
        state_d      = state_q;
        seed_full_d  = seed_full_q;
        prng_seed_d  = prng_seed_q;
        reseed_due_d = reseed_due_q;
        count_d      = count_q;
        rr_d         = rr_q;
        hold_d       = core_valid_in & ~core_in_ready;
        hold_idx_d   = g_idx;
        tag_mem_d    = tag_mem_q;
        tag_wr_d     = tag_wr_q;
        tag_rd_d     = tag_rd_q;
        tag_cnt_d    = tag_cnt_q + TC_W'(accept) - TC_W'(pop);

        if (in_seed_valid && !seed_full_q) begin
            prng_seed_d = in_seed;
            seed_full_d = 1'b1;
        end

        if (accept) begin
            rr_d                = (g_idx == CH_W'(NCH - 1)) ? '0 : g_idx + 1'b1;
            tag_mem_d[tag_wr_q] = g_idx;
            tag_wr_d            = tag_wr_q + 1'b1;
            count_d             = (count_q == '1) ? count_q : count_q + 1'b1;
            if (RESEED_PERIOD != 0 && (32'(count_q) + 32'd1 >= 32'(RESEED_PERIOD))) begin
                reseed_due_d = 1'b1;
            end
        end
        if (pop) begin
            tag_rd_d = tag_rd_q + 1'b1;
        end

        // An auto reseed still needs a buffered seed, so DRAIN waits for one.
        case (state_q)
            ST_IDLE:  if (seed_full_q || reseed_due_q) state_d = ST_DRAIN;
            ST_DRAIN: if (!core_busy && fifo_empty && !hold_q && !core_valid_in && seed_full_q)
                          state_d = ST_START;
            ST_START: begin
                seed_full_d = 1'b0;
                state_d     = ST_WAITB;
            end
            ST_WAITB: if (prng_busy) state_d = ST_RUN;
            ST_RUN: if (!prng_busy) begin
                state_d      = ST_IDLE;
                count_d      = '0;
                reseed_due_d = 1'b0;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            seed_full_q  <= 1'b0;
            prng_seed_q  <= '0;
            reseed_due_q <= 1'b0;
            count_q      <= '0;
            rr_q         <= '0;
            hold_q       <= 1'b0;
            hold_idx_q   <= '0;
            tag_mem_q    <= '{default: '0};
            tag_wr_q     <= '0;
            tag_rd_q     <= '0;
            tag_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            seed_full_q  <= seed_full_d;
            prng_seed_q  <= prng_seed_d;
            reseed_due_q <= reseed_due_d;
            count_q      <= count_d;
            rr_q         <= rr_d;
            hold_q       <= hold_d;
            hold_idx_q   <= hold_idx_d;
            tag_mem_q    <= tag_mem_d;
            tag_wr_q     <= tag_wr_d;
            tag_rd_q     <= tag_rd_d;
            tag_cnt_q    <= tag_cnt_d;
        end
    end

    assign out_ch            = fifo_empty ? '0 : tag_mem_q[tag_rd_q];
    assign out_valid         = core_cipher_valid;
    assign core_out_ready    = out_ready;
    assign in_seed_ready     = ~seed_full_q;
    assign prng_seed         = prng_seed_q;
    assign prng_start_reseed = (state_q == ST_START);
    assign reseed_due        = reseed_due_q;

endmodule

// File: tb/tb_aes_enc_mch_reseed_ctrl.sv
// Bench for aes_enc_mch_reseed_ctrl with NCH=4, RESEED_PERIOD=3; expectations come from queue/counter model.
module tb_aes_enc_mch_reseed_ctrl;

    localparam int D = 2, NCH = 4, SEED_W = 80, RP = 3, CNT_W = 16;
    localparam int CH_W = 2;
    localparam int SW = 128 * D;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_valid, ch_ready;
    logic [NCH*SW-1:0] ch_shares_pt, ch_shares_key;
    logic              core_valid_in, core_in_ready, core_busy;
    logic [SW-1:0]     core_shares_pt, core_shares_key;
    logic              core_cipher_valid, core_out_ready, out_valid, out_ready;
    logic [CH_W-1:0]   out_ch;
    logic              in_seed_valid, in_seed_ready;
    logic [SEED_W-1:0] in_seed, prng_seed;
    logic              prng_start_reseed, prng_busy, prng_out_valid, reseed_due;

    int checks = 0;
    int failures = 0;
    int m_ptr = 0;
    int m_count = 0;
    int m_tags[$];

    always #5 clk = ~clk;

    aes_enc_mch_reseed_ctrl #(
        .d(D), .NCH(NCH), .SEED_W(SEED_W), .RESEED_PERIOD(RP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_shares_pt(ch_shares_pt), .ch_shares_key(ch_shares_key),
        .core_valid_in(core_valid_in), .core_in_ready(core_in_ready), .core_busy(core_busy),
        .core_shares_pt(core_shares_pt), .core_shares_key(core_shares_key),
        .core_cipher_valid(core_cipher_valid), .core_out_ready(core_out_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .in_seed_valid(in_seed_valid), .in_seed_ready(in_seed_ready), .in_seed(in_seed),
        .prng_seed(prng_seed), .prng_start_reseed(prng_start_reseed),
        .prng_busy(prng_busy), .prng_out_valid(prng_out_valid), .reseed_due(reseed_due)
    );

    function automatic logic [SW-1:0] rnd_share();
        logic [SW-1:0] v;
        for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [SEED_W-1:0] rnd_seed();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[SEED_W-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ch_valid = '0; core_in_ready = 1'b0; core_busy = 1'b0; core_cipher_valid = 1'b0;
        out_ready = 1'b0; in_seed_valid = 1'b0; in_seed = '0; prng_busy = 1'b0;
        prng_out_valid = 1'b0; ch_shares_pt = '0; ch_shares_key = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ch_ready !== '0) begin failures++; $display("FAIL reset_ch_ready got=%0h exp=0", ch_ready); end
        checks++; if (core_valid_in !== 1'b0) begin failures++; $display("FAIL reset_core_valid got=%0b exp=0", core_valid_in); end
        checks++; if (out_ch !== '0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
        checks++; if (in_seed_ready !== 1'b1) begin failures++; $display("FAIL reset_seed_ready got=%0b exp=1", in_seed_ready); end
        checks++; if (prng_seed !== '0) begin failures++; $display("FAIL reset_prng_seed got=%0h exp=0", prng_seed); end
        checks++; if (prng_start_reseed !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%0b exp=0", prng_start_reseed); end
        checks++; if (reseed_due !== 1'b0) begin failures++; $display("FAIL reset_due got=%0b exp=0", reseed_due); end
        rst = 1'b0;
    endtask

    task automatic accept_one(input logic [NCH-1:0] mask);
        int g;
        @(negedge clk);
        ch_valid = mask; core_in_ready = 1'b1; prng_out_valid = 1'b1; core_cipher_valid = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            ch_shares_pt[c*SW +: SW]  = rnd_share();
            ch_shares_key[c*SW +: SW] = rnd_share();
        end
        #1;
        g = -1;
        for (int i = 0; i < NCH; i++) if (g < 0 && mask[(m_ptr + i) % NCH]) g = (m_ptr + i) % NCH;
        checks++; if (core_valid_in !== 1'b1) begin failures++; $display("FAIL acc_valid got=%0b exp=1", core_valid_in); end
        checks++; if (ch_ready !== (4'b1 << g)) begin failures++; $display("FAIL acc_grant got=%0h exp=%0h", ch_ready, 4'b1 << g); end
        checks++;
        if (core_shares_pt !== ch_shares_pt[g*SW +: SW] || core_shares_key !== ch_shares_key[g*SW +: SW]) begin
            failures++; $display("FAIL acc_mux got=%0h exp=%0h", core_shares_pt, ch_shares_pt[g*SW +: SW]);
        end
        @(posedge clk);
        m_ptr = (g + 1) % NCH; m_tags.push_back(g); m_count++;
        #1;
        ch_valid = '0;
        checks++; if (reseed_due !== (m_count >= RP)) begin failures++; $display("FAIL acc_due got=%0b exp=%0b", reseed_due, m_count >= RP); end
    endtask

    task automatic pop_one();
        @(negedge clk);
        ch_valid = '0; core_cipher_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || core_out_ready !== 1'b1) begin failures++; $display("FAIL pop_hs got=%0b%0b exp=11", out_valid, core_out_ready); end
        checks++;
        if (m_tags.size() == 0) begin failures++; $display("FAIL pop_model_empty got=0 exp>0"); end
        else if (out_ch !== CH_W'(m_tags[0])) begin failures++; $display("FAIL pop_tag got=%0d exp=%0d", out_ch, m_tags[0]); end
        @(posedge clk);
        if (m_tags.size() > 0) void'(m_tags.pop_front());
        #1;
        core_cipher_valid = 1'b0;
    endtask

    task automatic drain_tags();
        while (m_tags.size() > 0) pop_one();
    endtask

    task automatic do_reseed(input logic [SEED_W-1:0] s, input int busy_cyc);
        int pulses;
        bit seen;
        pulses = 0; seen = 0;
        @(negedge clk);
        ch_valid = '0; in_seed = s; in_seed_valid = 1'b1; core_busy = (busy_cyc > 0);
        prng_out_valid = 1'b1; core_in_ready = 1'b1;
        #1;
        checks++; if (in_seed_ready !== 1'b1) begin failures++; $display("FAIL seed_ready_in got=%0b exp=1", in_seed_ready); end
        @(posedge clk);
        #1;
        in_seed_valid = 1'b0; ch_valid = '1;
        for (int i = 0; i < busy_cyc; i++) begin
            @(negedge clk); #1;
            checks++;
            if (prng_start_reseed !== 1'b0 || in_seed_ready !== 1'b0 || core_valid_in !== 1'b0) begin
                failures++; $display("FAIL busy_hold got=%0b%0b%0b exp=000", prng_start_reseed, in_seed_ready, core_valid_in);
            end
        end
        @(negedge clk);
        core_busy = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (in_seed_ready !== 1'b0 || core_valid_in !== 1'b0) begin
                failures++; $display("FAIL pre_start got=%0b%0b exp=00", in_seed_ready, core_valid_in);
            end
            if (prng_start_reseed === 1'b1) begin
                seen = 1; pulses++;
                checks++; if (prng_seed !== s) begin failures++; $display("FAIL prng_seed got=%0h exp=%0h", prng_seed, s); end
            end
        end
        if (!seen) begin checks++; failures++; $display("FAIL start_timeout got=0 exp=1"); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            prng_busy = 1'b1;
            #1;
            if (prng_start_reseed === 1'b1) pulses++;
            checks++;
            if (ch_ready !== '0 || core_valid_in !== 1'b0 || in_seed_ready !== 1'b1) begin
                failures++; $display("FAIL run_block got=%0h%0b%0b exp=001", ch_ready, core_valid_in, in_seed_ready);
            end
        end
        @(negedge clk);
        prng_busy = 1'b0;
        #1;
        if (prng_start_reseed === 1'b1) pulses++;
        checks++; if (core_valid_in !== 1'b0) begin failures++; $display("FAIL run_last got=%0b exp=0", core_valid_in); end
        @(posedge clk);
        m_count = 0;
        @(negedge clk); #1;
        checks++; if (reseed_due !== 1'b0) begin failures++; $display("FAIL due_clear got=%0b exp=0", reseed_due); end
        checks++; if (core_valid_in !== 1'b1) begin failures++; $display("FAIL resume got=%0b exp=1", core_valid_in); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL pulse_count got=%0d exp=1", pulses); end
        ch_valid = '0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 3; i++) begin accept_one('1); pop_one(); end
        do_reseed(rnd_seed(), 3);
        for (int i = 0; i < 3; i++) begin accept_one('1); pop_one(); end
    endtask

    task automatic test_stall_no_seed();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ch_valid = '1; prng_out_valid = 1'b1; core_in_ready = 1'b1;
            #1;
            checks++;
            if (reseed_due !== 1'b1 || core_valid_in !== 1'b0 || ch_ready !== '0 || prng_start_reseed !== 1'b0) begin
                failures++; $display("FAIL stall got=%0b%0b%0h%0b exp=1000", reseed_due, core_valid_in, ch_ready, prng_start_reseed);
            end
        end
        ch_valid = '0;
        do_reseed(rnd_seed(), 0);
    endtask

    task automatic test_fifo_full();
        accept_one(4'b0110);
        accept_one(4'b1001);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ch_valid = '1; core_cipher_valid = 1'b1; out_ready = 1'b0;
            #1;
            checks++; if (core_valid_in !== 1'b0) begin failures++; $display("FAIL full_block got=%0b exp=0", core_valid_in); end
            checks++; if (out_ch !== CH_W'(m_tags[0]) || core_out_ready !== 1'b0) begin failures++; $display("FAIL full_head got=%0d exp=%0d", out_ch, m_tags[0]); end
        end
        ch_valid = '0;
        pop_one();
        pop_one();
        @(negedge clk); #1;
        checks++; if (out_ch !== '0) begin failures++; $display("FAIL empty_out_ch got=%0d exp=0", out_ch); end
    endtask

    task automatic test_random();
        repeat (24) begin
            if (m_count >= RP) begin
                drain_tags();
                do_reseed(rnd_seed(), $urandom_range(0, 2));
            end else begin
                if (m_tags.size() == 2) pop_one();
                accept_one(4'($urandom_range(1, 15)));
                if ($urandom_range(0, 1) == 1) pop_one();
            end
        end
        drain_tags();
        if (m_count >= RP) do_reseed(rnd_seed(), 0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        accept_one(4'b0100);
        pop_one();
        @(negedge clk);
        in_seed = rnd_seed(); in_seed_valid = 1'b1; ch_valid = '0;
        @(posedge clk); #1;
        in_seed_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            if (prng_start_reseed === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL mid_start_timeout got=0 exp=1"); end
        repeat (2) begin @(negedge clk); prng_busy = 1'b1; end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_seed_ready !== 1'b1 || prng_seed !== '0 || reseed_due !== 1'b0 || prng_start_reseed !== 1'b0 ||
            out_ch !== '0 || core_valid_in !== 1'b0 || ch_ready !== '0) begin
            failures++; $display("FAIL mid_reset_async got=%0b%0b%0b exp=100", in_seed_ready, reseed_due, prng_start_reseed);
        end
        @(posedge clk); #1;
        checks++; if (in_seed_ready !== 1'b1 || prng_seed !== '0) begin failures++; $display("FAIL mid_reset_edge got=%0b/%0h exp=1/0", in_seed_ready, prng_seed); end
        @(negedge clk);
        rst = 1'b0; prng_busy = 1'b0;
        m_ptr = 0; m_count = 0; m_tags.delete();
        accept_one('1);
        pop_one();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall_no_seed();
        test_fifo_full();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
